dma_stream_feeder: RTL

Upstream stage for the AXI burst write DMA. Accepts a valid/ready stream of 32-bit words into an internal FIFO, carves it into bursts of at most 16 words that never cross a 64-byte boundary, and drives the DMA's start/addr/burstlen/data inputs while consuming its advance/busy outputs. Destination addresses walk a ring buffer in DDR defined by `cfg_base` and `cfg_bursts`, wrapping to the base.

---
 rtl/dma_stream_feeder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dma_stream_feeder.sv
// dma_stream_feeder
// Buffers a valid/ready stream of 32-bit words and splits it into DMA bursts.
// A burst holds at most 16 words and never crosses a 64-byte boundary.
// Destination addresses step through a ring buffer of cfg_bursts*16 words
// starting at cfg_base, and wrap back to the base at the end of the ring.
//
// Ports
//   clk, reset          single clock; synchronous active-high reset
//   enable, flush       permit new bursts; force a short burst from a partial fill
//   cfg_base/cfg_bursts ring base byte address and ring size in 16-word units
//   in_data/in_valid/in_ready  input stream
//   start/addr/burstlen/data   burst request and head-of-FIFO word to the DMA
//   busy/advance        DMA status and per-word consume strobe
//   wr_offset           committed ring offset in words
//   burst_done          one-cycle pulse per completed burst
//   fifo_count          current FIFO fill
module dma_stream_feeder #(
    parameter int FIFO_AW = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               flush,
    input  logic [31:0]        cfg_base,
    input  logic [15:0]        cfg_bursts,
    input  logic [31:0]        in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               start,
    output logic [31:0]        addr,
    output logic [3:0]         burstlen,
    output logic [31:0]        data,
    input  logic               busy,
    input  logic               advance,
    output logic [19:0]        wr_offset,
    output logic               burst_done,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL = {1'b1, {FIFO_AW{1'b0}}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [1:0]         state;
    logic [4:0]         remaining;

    logic               push;
    logic               pop;
    logic               trigger;
    logic               count_ge;
    logic [4:0]         to_bound;
    logic [4:0]         len;
    logic [4:0]         len_m1;
    logic [19:0]        ring_words;
    logic [20:0]        next_off;

    assign in_ready   = (fifo_count != FULL);
    assign push       = in_valid & in_ready;
    assign pop        = (state == ST_XFER) & advance & (remaining != 5'd0);
    assign start      = (state == ST_ISSUE);
    assign data       = mem[rd_ptr];

    // Words left before the next 16-word boundary; always 1..16.
    assign to_bound   = 5'd16 - {1'b0, wr_offset[3:0]};
    assign count_ge   = (fifo_count >= (FIFO_AW+1)'(to_bound));
    // When the fill is below to_bound it is at most 15, so it fits in 5 bits.
    assign len        = count_ge ? to_bound : fifo_count[4:0];
    assign len_m1     = len - 5'd1;
    assign trigger    = enable & (cfg_bursts != 16'd0) &
                        (count_ge | (flush & (fifo_count != '0)));

    assign ring_words = {cfg_bursts, 4'b0000};
    // burstlen still holds the committed burst length minus one in WAIT.
    assign next_off   = {1'b0, wr_offset} + {17'b0, burstlen} + 21'd1;

    // Storage has no reset; reset only empties the FIFO via the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            addr       <= '0;
            burstlen   <= '0;
            remaining  <= '0;
            wr_offset  <= '0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        addr      <= cfg_base + {10'b0, wr_offset, 2'b00};
                        burstlen  <= len_m1[3:0];
                        remaining <= len;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_XFER;
                end
                ST_XFER: begin
                    if (pop) begin
                        remaining <= remaining - 5'd1;
                        if (remaining == 5'd1) state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!busy) begin
                        // Ring size is read here, so a changed cfg_bursts
                        // takes effect at this commit.
                        if (next_off >= {1'b0, ring_words}) wr_offset <= '0;
                        else                                wr_offset <= next_off[19:0];
                        burst_done <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
